// File: rtl/keccak_pkg.sv
// keccak_pkg: shared definitions for the Keccak absorb front end.
//   - mode_e        : message mode codes carried on cmode (6/7 are reserved)
//   - state_e       : absorb padder FSM states
//   - rate_lanes()  : rate in 64-bit lanes per mode
//   - suffix_of()   : domain-separation suffix byte per mode
package keccak_pkg;
    localparam int         LANE_W         = 64;
    localparam int         MAX_RATE_LANES = 21;
    localparam logic [7:0] SFX_SHA3       = 8'h06;
    localparam logic [7:0] SFX_SHAKE      = 8'h1F;

    typedef enum logic [2:0] {
        MODE_SHA3_224 = 3'd0,
        MODE_SHA3_256 = 3'd1,
        MODE_SHA3_384 = 3'd2,
        MODE_SHA3_512 = 3'd3,
        MODE_SHAKE128 = 3'd4,
        MODE_SHAKE256 = 3'd5
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ABSORB = 2'd1,
        ST_PAD    = 2'd2
    } state_e;

    // Reserved codes fall back to the SHA3-256 rate.
    function automatic logic [4:0] rate_lanes(input logic [2:0] m);
        case (m)
            MODE_SHA3_224: return 5'd18;
            MODE_SHA3_256: return 5'd17;
            MODE_SHA3_384: return 5'd13;
            MODE_SHA3_512: return 5'd9;
            MODE_SHAKE128: return 5'd21;
            default:       return 5'd17;
        endcase
    endfunction

    // Reserved codes fall back to the SHA3 suffix.
    function automatic logic [7:0] suffix_of(input logic [2:0] m);
        return (m == MODE_SHAKE128 || m == MODE_SHAKE256) ? SFX_SHAKE : SFX_SHA3;
    endfunction
endpackage

// File: rtl/keccak_pad_lane.sv
// keccak_pad_lane: combinational lane masker / padder.
//   lane_i          raw lane bytes (little-endian)
//   nbytes_i        number of leading message bytes kept (0..8)
//   place_suffix_i  put the mode suffix into byte nbytes_i
//   place_final_i   OR 0x80 into byte 7 (last lane of the rate block)
//   mode_i          message mode, selects the suffix
//   lane_o          masked and padded lane
module keccak_pad_lane
    import keccak_pkg::*;
(
    input  logic [LANE_W-1:0] lane_i,
    input  logic [3:0]        nbytes_i,
    input  logic              place_suffix_i,
    input  logic              place_final_i,
    input  logic [2:0]        mode_i,
    output logic [LANE_W-1:0] lane_o
);
    logic [7:0] sfx;
    assign sfx = suffix_of(mode_i);

    always_comb begin
        lane_o = '0;
        for (int k = 0; k < 8; k++) begin
            if (4'(k) < nbytes_i)
                lane_o[8*k +: 8] = lane_i[8*k +: 8];
            // The suffix byte sits just past the data, which is already zero here.
            if (place_suffix_i && 4'(k) == nbytes_i)
                lane_o[8*k +: 8] = sfx;
        end
        if (place_final_i)
            lane_o[63:56] = lane_o[63:56] | 8'h80;
    end
endmodule

// File: rtl/keccak_absorb_padder.sv
// keccak_absorb_padder: packs a byte stream into 64-bit lanes, applies the
// domain suffix and pad10*1, and presents lanes to the permutation core.
//   clk_i/rst_i                 clock, async active-high reset
//   start_i/cmode_i             begin a message in the given mode (IDLE only)
//   in_valid_i/in_ready_o       input word handshake
//   in_data_i/in_last_i/in_bytes_i  word, end-of-message, valid bytes in last word
//   lane_valid_o/lane_ready_i   lane handshake
//   lane_data_o/lane_idx_o      padded lane and its index in the rate block
//   lane_blk_last_o/lane_msg_last_o  block end / message end markers
//   busy_o                      message in flight
//   err_mode_o                  sticky: last start used a reserved mode
module keccak_absorb_padder
    import keccak_pkg::*;
#(
    parameter int DIN_W = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic [2:0]                 cmode_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [DIN_W-1:0]           in_data_i,
    input  logic                       in_last_i,
    input  logic [$clog2(DIN_W/8):0]   in_bytes_i,
    output logic                       lane_valid_o,
    input  logic                       lane_ready_i,
    output logic [LANE_W-1:0]          lane_data_o,
    output logic [4:0]                 lane_idx_o,
    output logic                       lane_blk_last_o,
    output logic                       lane_msg_last_o,
    output logic                       busy_o,
    output logic                       err_mode_o
);
    localparam int WORD_B = DIN_W / 8;

    state_e      state_q, state_d;
    logic [2:0]  mode_q, mode_d;
    logic [4:0]  rate_q, rate_d, cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] asm_q, asm_d;          // low half of a lane (DIN_W=32 only)
    logic        half_q, half_d;        // low half holds data
    logic        flush_q, flush_d;      // final short half-word waiting for the output register
    logic [3:0]  nbq_q, nbq_d;
    logic        sfx_pend_q, sfx_pend_d; // suffix still owed to a PAD lane
    logic        done_q, done_d;        // msg_last lane already loaded
    logic        vld_q, vld_d, blk_q, blk_d, msg_q, msg_d;
    logic [63:0] data_q, data_d;
    logic [4:0]  idx_q, idx_d;

    logic        out_free, at_last, emit, fin, psfx, pfin, in_ready;
    logic [3:0]  nb_in, nb;
    logic [63:0] din_ext, raw, padded;

    assign out_free = !vld_q || lane_ready_i;
    assign at_last  = (cnt_q == rate_q - 5'd1);
    assign din_ext  = 64'(in_data_i);
    assign nb_in    = (4'(in_bytes_i) > 4'(WORD_B)) ? 4'(WORD_B) : 4'(in_bytes_i);

    keccak_pad_lane u_pad (
        .lane_i         (raw),
        .nbytes_i       (nb),
        .place_suffix_i (psfx),
        .place_final_i  (pfin),
        .mode_i         (mode_q),
        .lane_o         (padded)
    );

    always_comb begin
        state_d = state_q; mode_d = mode_q; rate_d = rate_q; err_d = err_q; cnt_d = cnt_q;
        asm_d = asm_q; half_d = half_q; flush_d = flush_q; nbq_d = nbq_q;
        sfx_pend_d = sfx_pend_q; done_d = done_q;
        emit = 1'b0; raw = din_ext; nb = 4'd8; fin = 1'b0; psfx = 1'b0; pfin = 1'b0;
        in_ready = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_ABSORB; mode_d = cmode_i; rate_d = rate_lanes(cmode_i);
                    err_d = (cmode_i == 3'd6) || (cmode_i == 3'd7);
                    cnt_d = '0; half_d = 1'b0; flush_d = 1'b0; sfx_pend_d = 1'b0; done_d = 1'b0;
                end
            end
            ST_ABSORB: begin
                if (DIN_W == 64) begin
                    in_ready = out_free;
                    if (in_valid_i && out_free) begin
                        emit = 1'b1; fin = in_last_i;
                        if (in_last_i) nb = nb_in;
                    end
                end else if (flush_q) begin
                    if (out_free) begin
                        emit = 1'b1; raw = {32'b0, asm_q}; nb = nbq_q; fin = 1'b1; flush_d = 1'b0;
                    end
                end else if (!half_q) begin
                    // Low half never needs the output register unless it ends the message.
                    in_ready = 1'b1;
                    if (in_valid_i) begin
                        if (!in_last_i) begin
                            asm_d = din_ext[31:0]; half_d = 1'b1;
                        end else if (out_free) begin
                            emit = 1'b1; raw = {32'b0, din_ext[31:0]}; nb = nb_in; fin = 1'b1;
                        end else begin
                            asm_d = din_ext[31:0]; nbq_d = nb_in; flush_d = 1'b1;
                        end
                    end
                end else begin
                    in_ready = out_free;
                    if (in_valid_i && out_free) begin
                        emit = 1'b1; raw = {din_ext[31:0], asm_q}; fin = in_last_i; half_d = 1'b0;
                        if (in_last_i) nb = 4'd4 + nb_in;
                    end
                end
                // A full final lane leaves the suffix (and maybe the 0x80) to PAD.
                if (emit && fin) begin
                    psfx = (nb != 4'd8);
                    pfin = psfx && at_last;
                    state_d = ST_PAD; sfx_pend_d = !psfx; done_d = pfin;
                end
            end
            ST_PAD: begin
                if (!done_q && out_free) begin
                    emit = 1'b1; raw = '0; nb = 4'd0; psfx = sfx_pend_q; pfin = at_last;
                    sfx_pend_d = 1'b0; done_d = at_last;
                end
                if (vld_q && lane_ready_i && msg_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (emit) cnt_d = at_last ? 5'd0 : cnt_q + 5'd1;

        vld_d = emit ? 1'b1 : (lane_ready_i ? 1'b0 : vld_q);
        data_d = emit ? padded  : data_q;
        idx_d  = emit ? cnt_q   : idx_q;
        blk_d  = emit ? at_last : blk_q;
        msg_d  = emit ? pfin    : msg_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE; mode_q <= '0; rate_q <= 5'd17; err_q <= 1'b0; cnt_q <= '0;
            asm_q <= '0; half_q <= 1'b0; flush_q <= 1'b0; nbq_q <= '0;
            sfx_pend_q <= 1'b0; done_q <= 1'b0;
            vld_q <= 1'b0; data_q <= '0; idx_q <= '0; blk_q <= 1'b0; msg_q <= 1'b0;
        end else begin
            state_q <= state_d; mode_q <= mode_d; rate_q <= rate_d; err_q <= err_d; cnt_q <= cnt_d;
            asm_q <= asm_d; half_q <= half_d; flush_q <= flush_d; nbq_q <= nbq_d;
            sfx_pend_q <= sfx_pend_d; done_q <= done_d;
            vld_q <= vld_d; data_q <= data_d; idx_q <= idx_d; blk_q <= blk_d; msg_q <= msg_d;
        end
    end

    assign in_ready_o      = in_ready;
    assign lane_valid_o    = vld_q;
    assign lane_data_o     = data_q;
    assign lane_idx_o      = idx_q;
    assign lane_blk_last_o = blk_q;
    assign lane_msg_last_o = msg_q;
    assign busy_o          = (state_q != ST_IDLE);
    assign err_mode_o      = err_q;
endmodule

// File: tb/tb_keccak_absorb_padder.sv
// Bench for keccak_absorb_padder: one 64-bit and one 32-bit instance. A byte
// level pad10*1 model builds the expected lane list per message; a compare
// process per instance checks every valid lane cycle against it.
module tb_keccak_absorb_padder;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic s64, iv64, ir64, il64, lv64, lr64, bl64, ml64, busy64, err64;
    logic [2:0] cm64; logic [63:0] d64, ld64; logic [3:0] ib64; logic [4:0] li64;
    logic s32, iv32, ir32, il32, lv32, lr32, bl32, ml32, busy32, err32;
    logic [2:0] cm32; logic [31:0] d32; logic [63:0] ld32; logic [2:0] ib32; logic [4:0] li32;

    keccak_absorb_padder #(.DIN_W(64)) dut64 (
        .clk_i(clk), .rst_i(rst), .start_i(s64), .cmode_i(cm64), .in_valid_i(iv64),
        .in_ready_o(ir64), .in_data_i(d64), .in_last_i(il64), .in_bytes_i(ib64),
        .lane_valid_o(lv64), .lane_ready_i(lr64), .lane_data_o(ld64), .lane_idx_o(li64),
        .lane_blk_last_o(bl64), .lane_msg_last_o(ml64), .busy_o(busy64), .err_mode_o(err64));
    keccak_absorb_padder #(.DIN_W(32)) dut32 (
        .clk_i(clk), .rst_i(rst), .start_i(s32), .cmode_i(cm32), .in_valid_i(iv32),
        .in_ready_o(ir32), .in_data_i(d32), .in_last_i(il32), .in_bytes_i(ib32),
        .lane_valid_o(lv32), .lane_ready_i(lr32), .lane_data_o(ld32), .lane_idx_o(li32),
        .lane_blk_last_o(bl32), .lane_msg_last_o(ml32), .busy_o(busy32), .err_mode_o(err32));

    typedef struct packed { logic [63:0] data; logic [4:0] idx; logic bl; logic ml; } lane_t;
    lane_t exp64[$], exp32[$];
    logic [63:0] got64[$], got32[$];
    logic [7:0] msg_q[$];
    int checks = 0, errors = 0;
    bit rnd64 = 0, rnd32 = 0, hold32 = 0;

    function automatic int rate_of(input int m);
        case (m)
            0: return 18; 1: return 17; 2: return 13; 3: return 9; 4: return 21;
            default: return 17;
        endcase
    endfunction

    // Message -> padded byte string -> lanes.
    task automatic model(input bit w32, input int mode);
        int R, rb, len, tot; lane_t e; logic [7:0] pb [0:4095];
        R = rate_of(mode); rb = R * 8; len = msg_q.size();
        tot = ((len + rb) / rb) * rb;
        for (int i = 0; i < tot; i++) pb[i] = (i < len) ? msg_q[i] : 8'h00;
        pb[len] = pb[len] | ((mode == 4 || mode == 5) ? 8'h1F : 8'h06);
        pb[tot-1] = pb[tot-1] | 8'h80;
        for (int l = 0; l < tot / 8; l++) begin
            for (int b = 0; b < 8; b++) e.data[8*b +: 8] = pb[8*l + b];
            e.idx = 5'(l % R); e.bl = ((l % R) == R - 1); e.ml = (l == tot / 8 - 1);
            if (w32) exp32.push_back(e); else exp64.push_back(e);
        end
    endtask

    task automatic pin(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    always @(negedge clk) if (!rst && lv64) begin
        checks++;
        if (exp64.size() == 0) begin
            errors++; $display("FAIL lane64_extra: got %h idx %0d, expected no lane", ld64, li64);
        end else if ({ld64, li64, bl64, ml64} !== exp64[0]) begin
            errors++;
            $display("FAIL lane64: got %h/%0d/%b/%b expected %h/%0d/%b/%b", ld64, li64, bl64, ml64,
                     exp64[0].data, exp64[0].idx, exp64[0].bl, exp64[0].ml);
        end
        if (lr64) begin got64.push_back(ld64); if (exp64.size() != 0) void'(exp64.pop_front()); end
    end

    always @(negedge clk) if (!rst && lv32) begin
        checks++;
        if (exp32.size() == 0) begin
            errors++; $display("FAIL lane32_extra: got %h idx %0d, expected no lane", ld32, li32);
        end else if ({ld32, li32, bl32, ml32} !== exp32[0]) begin
            errors++;
            $display("FAIL lane32: got %h/%0d/%b/%b expected %h/%0d/%b/%b", ld32, li32, bl32, ml32,
                     exp32[0].data, exp32[0].idx, exp32[0].bl, exp32[0].ml);
        end
        if (lr32) begin got32.push_back(ld32); if (exp32.size() != 0) void'(exp32.pop_front()); end
    end

    initial begin
        lr64 = 1'b1; lr32 = 1'b1;
        forever begin
            @(posedge clk); #1;
            lr64 = rnd64 ? ($urandom_range(0, 2) != 0) : 1'b1;
            lr32 = hold32 ? 1'b0 : (rnd32 ? ($urandom_range(0, 2) != 0) : 1'b1);
        end
    end

    task automatic drive_word(input bit w32, input logic [63:0] word, input bit last, input int n,
                              input bit over);
        int t = 0; bit acc = 0;
        if (w32) begin
            d32 = word[31:0]; il32 = last; ib32 = last ? 3'(n) : 3'($urandom); iv32 = 1'b1;
        end else begin
            d64 = word; il64 = last; iv64 = 1'b1;
            ib64 = !last ? 4'($urandom) : ((over && n == 8) ? 4'd12 : 4'(n));
        end
        while (!acc && t < 300) begin
            @(negedge clk); acc = w32 ? ir32 : ir64;
            @(posedge clk); #1; t++;
        end
        if (w32) iv32 = 1'b0; else iv64 = 1'b0;
        checks++;
        if (!acc) begin errors++; $display("FAIL accept_timeout: got no in_ready, expected accept"); end
    endtask

    task automatic wait_idle(input bit w32);
        int t = 0;
        while ((w32 ? busy32 : busy64) && t < 3000) begin @(posedge clk); #1; t++; end
        pin("busy_timeout", 64'(t >= 3000), 64'd0);
        pin("lanes_left", 64'(w32 ? exp32.size() : exp64.size()), 64'd0);
    endtask

    task automatic start_msg(input bit w32, input int mode);
        if (w32) begin s32 = 1'b1; cm32 = 3'(mode); end else begin s64 = 1'b1; cm64 = 3'(mode); end
        @(posedge clk); #1; s32 = 1'b0; s64 = 1'b0;
        pin("err_mode", 64'(w32 ? err32 : err64), (mode >= 6) ? 64'd1 : 64'd0);
    endtask

    task automatic send_msg(input bit w32, input int mode, input bit over);
        int wb, len, nw; logic [63:0] word;
        wb = w32 ? 4 : 8; len = msg_q.size(); nw = (len == 0) ? 1 : (len + wb - 1) / wb;
        model(w32, mode);
        if (w32) got32.delete(); else got64.delete();
        start_msg(w32, mode);
        for (int w = 0; w < nw; w++) begin
            word = '0;
            for (int b = 0; b < wb; b++)
                word[8*b +: 8] = (w*wb + b < len) ? msg_q[w*wb + b] : 8'hEE;
            drive_word(w32, word, w == nw - 1, len - w*wb, over);
        end
        wait_idle(w32);
    endtask

    task automatic fill(input int len, input int kind);
        msg_q.delete();
        for (int i = 0; i < len; i++)
            msg_q.push_back(kind == 0 ? 8'hFF : (kind == 1 ? 8'(i) : 8'($urandom_range(0, 255))));
    endtask

    initial begin
        logic [63:0] word;
        rst = 1'b1; s64 = 0; iv64 = 0; il64 = 0; cm64 = 0; d64 = 0; ib64 = 0;
        s32 = 0; iv32 = 0; il32 = 0; cm32 = 0; d32 = 0; ib32 = 0;
        #2;
        pin("rst64_ctrl", {58'b0, ir64, lv64, bl64, ml64, busy64, err64}, 64'd0);
        pin("rst64_data", ld64 | 64'(li64), 64'd0);
        pin("rst32_ctrl", {58'b0, ir32, lv32, bl32, ml32, busy32, err32}, 64'd0);
        pin("rst32_data", ld32 | 64'(li32), 64'd0);
        @(negedge clk); rst = 1'b0; @(posedge clk); #1;

        // Empty SHA3-256.
        msg_q.delete(); send_msg(0, 1, 0);
        pin("empty_n", 64'(got64.size()), 64'd17);
        pin("empty_l0", got64[0], 64'h06);
        pin("empty_l16", got64[16], 64'h8000_0000_0000_0000);
        // SHA3-512, 16 full words: second block carries the suffix.
        fill(128, 0); send_msg(0, 3, 0);
        pin("s512_n", 64'(got64.size()), 64'd18);
        pin("s512_l8", got64[8], 64'hFFFF_FFFF_FFFF_FFFF);
        pin("s512_l16", got64[16], 64'h06);
        pin("s512_l17", got64[17], 64'h8000_0000_0000_0000);
        // SHAKE256, 3 bytes.
        msg_q = '{8'hAA, 8'hBB, 8'hCC}; send_msg(0, 5, 0);
        pin("shake_l0", got64[0], 64'h0000_0000_1FCC_BBAA);
        pin("shake_n", 64'(got64.size()), 64'd17);
        // SHA3-512, suffix and final bit share byte 7 of lane 8.
        fill(71, 0); send_msg(0, 3, 0);
        pin("merge_n", 64'(got64.size()), 64'd9);
        pin("merge_l8", got64[8], 64'h86FF_FFFF_FFFF_FFFF);
        // SHA3-512, exactly one block, over-range in_bytes, random backpressure.
        rnd64 = 1; fill(72, 0); send_msg(0, 3, 1);
        pin("padblk_n", 64'(got64.size()), 64'd18);
        pin("padblk_l9", got64[9], 64'h06);
        pin("padblk_l17", got64[17], 64'h8000_0000_0000_0000);
        fill(20, 2); send_msg(0, 4, 0);
        fill(143, 1); send_msg(0, 0, 0);
        pin("s224_top", got64[17] >> 56, 64'h86);
        rnd64 = 0;

        // DIN_W=32, reserved mode, random backpressure.
        rnd32 = 1; fill(37, 2); send_msg(1, 7, 0);
        pin("err_sticky", 64'(err32), 64'd1);
        fill(12, 2); send_msg(1, 4, 0);
        fill(16, 1); send_msg(1, 2, 0);
        pin("w32_n", 64'(got32.size()), 64'd13);
        pin("w32_l0", got32[0], 64'h0706_0504_0302_0100);
        pin("w32_l2", got32[2], 64'h06);
        msg_q.delete(); send_msg(1, 5, 0);
        pin("w32_empty_l0", got32[0], 64'h1F);
        rnd32 = 0;

        // Reset in the middle of a block while lane 0 is stalled.
        hold32 = 1; fill(64, 1); model(1, 7); start_msg(1, 7);
        for (int w = 0; w < 3; w++) begin
            word = '0;
            for (int b = 0; b < 4; b++) word[8*b +: 8] = msg_q[w*4 + b];
            drive_word(1, word, 1'b0, 4, 1'b0);
        end
        d32 = 32'h0F0E_0D0C; il32 = 1'b0; iv32 = 1'b1;
        repeat (3) @(posedge clk);
        #4 rst = 1'b1;
        #1;
        pin("midrst_ctrl", {59'b0, lv32, busy32, ir32, err32, ml32}, 64'd0);
        pin("midrst_data", ld32, 64'd0);
        iv32 = 1'b0;
        @(negedge clk); rst = 1'b0; exp32.delete(); hold32 = 0;
        @(posedge clk); #1;
        fill(5, 2); send_msg(1, 1, 0);
        pin("after_rst_n", 64'(got32.size()), 64'd17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/keccak_absorb_padder.md
# keccak_absorb_padder

Stream-side front end for the Keccak permutation core. Accepts a message as a valid/ready word stream of parametrised width and packs it into 64-bit lanes. Applies FIPS 202 domain suffix and pad10*1 padding for the selected mode. Emits lanes, with lane index and block/message end markers, to the absorb port of the permutation core.

## Interface
Parameters:
- DIN_W, 64, input word width; legal values 32 or 64.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle pulse; latches cmode; accepted in IDLE only.
- cmode  in  3  mode: 0 SHA3-224 (18 lanes), 1 SHA3-256 (17), 2 SHA3-384 (13), 3 SHA3-512 (9), 4 SHAKE128 (21), 5 SHAKE256 (17); 6/7 reserved.
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted when in_valid && in_ready.
- in_data  in  DIN_W  message bytes, little-endian; byte k is bits [8k+7:8k].
- in_last  in  1  final word of message.
- in_bytes  in  $clog2(DIN_W/8)+1  valid bytes in the final word (0..DIN_W/8); ignored when in_last=0.
- lane_valid  out  1  lane_data valid.
- lane_ready  in  1  downstream accepts the lane.
- lane_data  out  64  padded lane.
- lane_idx  out  5  lane position in rate block, 0..R-1.
- lane_blk_last  out  1  lane_idx == R-1.
- lane_msg_last  out  1  last lane of the message's final block.
- busy  out  1  high from accepted start until the msg_last lane is accepted.
- err_mode  out  1  sticky; set when start latches cmode 6/7. Cleared by rst or by a start with a legal cmode.

## Operation
- States: IDLE, ABSORB, PAD.
- IDLE to ABSORB on start. Latch R from the cmode table; reserved codes use R=17 with SHA3 suffix and set err_mode.
- ABSORB:
  - Accepted words fill the lane assembly register from the low end.
  - DIN_W=32: two words per lane, first word to bits [31:0].
  - A completed lane moves to the output register; lane counter increments and wraps R-1 to 0.
- Final word (in_last) with n = in_bytes valid bytes:
  - Bytes at positions ≥ n within the word are zeroed.
  - The first byte after the data gets the suffix: 0x06 for SHA3, 0x1F for SHAKE.
  - Remaining lane bytes are zero.
  - Byte 7 of lane R-1 gets OR 0x80. When the suffix lands on that same byte, it becomes 0x86 or 0x9F.
- If the final word exactly fills lane R-1, or leaves no room for the suffix, go to PAD.
  - PAD emits further lanes: the suffix lane first if not yet placed, then zero lanes, up to lane R-1 carrying 0x80<<56.
  - Otherwise PAD emits only the remaining zero lanes of the current block.
- The lane with lane_msg_last is accepted, then the block returns to IDLE.
- start while busy is ignored. in_bytes > DIN_W/8 is treated as DIN_W/8.

## Timing
- Reset values: in_ready=0, lane_valid=0, lane_data=0, lane_idx=0, lane_blk_last=0, lane_msg_last=0, busy=0, err_mode=0, state IDLE.
- in_ready = (state==ABSORB) && (!lane_valid || lane_ready) for DIN_W=64. For DIN_W=32, the first half-word is accepted whenever state==ABSORB.
- Latency: lane_valid rises the cycle after the word completing the lane is accepted.
- Throughput is one lane/clk under continuous lane_ready.
- Under backpressure (lane_valid && !lane_ready), lane_data, lane_idx and the markers hold stable.
- PAD emits one lane per accepted handshake. in_ready=0 in PAD and IDLE.
- rst mid-message: all state discarded, outputs return to reset values asynchronously; the next message needs a fresh start.

## Structure
- keccak_pkg holds:
  - the mode enum;
  - the rate-lane table (function of cmode);
  - the suffix constants SFX_SHA3=8'h06 and SFX_SHAKE=8'h1F;
  - LANE_W=64 and MAX_RATE_LANES=21.
- Sub-module keccak_pad_lane is combinational. Inputs: lane, byte count, place_suffix, place_final, mode. Output: masked and padded lane.
- The FSM, counters and output register stay in the top module.

## Test plan
- Empty SHA3-256 message (cmode=1, DIN_W=64): start, then in_last with in_bytes=0 → 17 lanes.
  - Lane 0 = 64'h06; lanes 1..15 = 0; lane 16 = 64'h8000_0000_0000_0000.
  - Lane 16 has blk_last=1 and msg_last=1.
- SHA3-512 (cmode=3), 16 words 64'hFFFF_FFFF_FFFF_FFFF, last in_bytes=8 → block 0: 9 lanes of all-ones, blk_last on lane 8, msg_last=0.
  - Block 1: lanes 0..6 all-ones, lane 7 = 64'h06, lane 8 = 64'h8000_0000_0000_0000 with msg_last.
- SHAKE256 (cmode=5), one word 64'h0000_0000_00CC_BBAA with in_bytes=3 → lane 0 = 64'h0000_0000_1FCC_BBAA.
  - Lanes 1..15 = 0; lane 16 = 64'h8000_0000_0000_0000.
- SHA3-512, 9 words all-ones, last in_bytes=7 → lane 8 = 64'h86FF_FFFF_FFFF_FFFF. Single block, msg_last on lane 8.
- SHA3-512, 9 full words, last in_bytes=8 → block 0 all data, no msg_last.
  - PAD block: lane 0 = 64'h06, lanes 1..7 = 0, lane 8 = 64'h8000_0000_0000_0000 with msg_last.
- DIN_W=32 with random lane_ready and cmode=7:
  - Lanes are assembled low-half-first; lane_data stays stable while stalled; err_mode=1.
  - rst pulsed mid-block → same cycle lane_valid=0, busy=0, in_ready=0, err_mode=0.
